// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: digit count, active-low
// segment patterns and the all-digits-off common pattern.
package stopwatch_pkg;

  localparam int NUM_DIG = 8;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [7:0] COM_OFF = 8'hFF;

  typedef logic [3:0] nibble_t;

  // True when nibbles idx..NUM_DIG-1 of v are all zero
  function automatic logic upper_zero(input logic [31:0] v, input logic [2:0] idx);
    logic z;
    z = 1'b1;
    for (int i = 0; i < NUM_DIG; i++) begin
      if ((i >= int'(idx)) && (v[4*i +: 4] != 4'h0)) z = 1'b0;
    end
    return z;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern; values above 9
// render as 'E' so a corrupted time value is visible on the display.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/stopwatch_fnd_scan.sv
// 8-digit multiplexed common-anode FND scanner. The time value is captured
// once per frame so a frame never mixes digits from two different values.
module stopwatch_fnd_scan
  import stopwatch_pkg::*;
#(
  parameter int         DWELL   = 2,
  parameter bit         LZB     = 1'b1,
  parameter logic [7:0] DP_MASK = 8'b0001_0100
) (
  input  logic        clk1k,
  input  logic        sw_reset,
  input  logic [31:0] val,
  input  logic        hold,
  output logic [7:0]  fnd_com,
  output logic [6:0]  fnd_seg,
  output logic        fnd_dp,
  output logic        frame_done
);

  localparam int             CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam bit             GUARD    = (DWELL >= 2);

  logic [CNT_W-1:0] cnt_p0;
  logic [2:0]       idx_p0;
  logic [31:0]      snap_p0;
  logic             cnt_end;
  logic             frame_end;

  assign cnt_end   = (cnt_p0 == CNT_LAST);
  assign frame_end = cnt_end && (idx_p0 == 3'd7);

  // Stage p0: dwell/digit counters and per-frame snapshot
  always_ff @(posedge clk1k or negedge sw_reset) begin
    if (!sw_reset) begin
      cnt_p0  <= '0;
      idx_p0  <= '0;
      snap_p0 <= '0;
    end else begin
      if (cnt_end) begin
        cnt_p0 <= '0;
        idx_p0 <= idx_p0 + 3'd1;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
      if (frame_end && !hold) snap_p0 <= val;
    end
  end

  logic [3:0] nib;
  logic [6:0] seg_dec;
  logic       blank;
  logic [6:0] seg_nxt;
  logic [7:0] com_nxt;
  logic       dp_nxt;

  assign nib = snap_p0[{idx_p0, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  // The all-off cycle at the start of each dwell hides segment changeover ghosting
  always_comb begin
    blank   = LZB && (idx_p0 != 3'd0) && upper_zero(snap_p0, idx_p0);
    seg_nxt = blank ? SEG_BLANK : seg_dec;
    com_nxt = ~(8'b1 << idx_p0);
    if (GUARD && (cnt_p0 == '0)) com_nxt = COM_OFF;
    dp_nxt  = ~DP_MASK[idx_p0];
  end

  // Stage p1: registered display outputs
  always_ff @(posedge clk1k or negedge sw_reset) begin
    if (!sw_reset) begin
      fnd_com    <= COM_OFF;
      fnd_seg    <= SEG_BLANK;
      fnd_dp     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      fnd_com    <= com_nxt;
      fnd_seg    <= seg_nxt;
      fnd_dp     <= dp_nxt;
      frame_done <= frame_end;
    end
  end

endmodule

// File: doc/stopwatch_fnd_scan.md
Name: stopwatch_fnd_scan

Overview:
- Display-side consumer of the stopwatch's 32-bit packed-BCD time value (8 nibbles, nibble 0 = least significant digit).
- Drives a multiplexed 8-digit common-anode 7-segment (FND) display from clk1k.
- Latches the value once per scan frame so the display never tears, and supports hold, leading-zero blanking and fixed decimal points.

Parameters:
- DWELL, 2, clk1k cycles per digit (>=1); frame = 8*DWELL cycles.
- LZB, 1, 1 = blank leading zeros (digit 0 is never blanked).
- DP_MASK, 8'b0001_0100, bit i = decimal point lit on digit i.

Ports:
- clk1k  input  1  scan clock, 1 kHz.
- sw_reset  input  1  reset, asynchronous, active-low.
- val  input  32  packed BCD from stopwatch; digit i = val[4i+3:4i].
- hold  input  1  1 = keep current snapshot at frame boundary.
- fnd_com  output  8  digit select, active-low; bit i = digit i.
- fnd_seg  output  7  {g,f,e,d,c,b,a}, active-low.
- fnd_dp  output  1  decimal point, active-low.
- frame_done  output  1  one-cycle pulse at end of each frame.

Behaviour:
- Reset (sw_reset=0, async, immediate): cnt=0, idx=0, snap=0, fnd_com=8'hFF, fnd_seg=7'h7F, fnd_dp=1, frame_done=0.
- Dwell counter cnt: 0..DWELL-1. At cnt==DWELL-1, cnt<=0 and idx<=idx+1, wrapping 7->0.
- Frame boundary (idx==7 && cnt==DWELL-1):
  - next cycle frame_done=1 for exactly one cycle;
  - snap<=val if hold==0, else snap unchanged.
- val or hold changes mid-frame have no visible effect until the next boundary.
- Outputs are registered with 1-cycle latency from (idx, cnt, snap).
- Ghost guard: when DWELL>=2, fnd_com=8'hFF during the cycle following cnt==0. Otherwise fnd_com=~(8'b1<<idx). With DWELL=1 there is no guard.
- Digit decode of nibble n = snap[4*idx+3:4*idx]:
  - 0-9 -> 7'h40, 79, 24, 30, 19, 12, 02, 78, 00, 10.
  - 0xA-0xF -> 'E' = 7'h06 (error).
  - Blank = 7'h7F.
- LZB: digit i (i>=1) is blank when LZB==1 and nibbles i..7 are all zero. Digit 0 always shows its value.
- fnd_dp=~DP_MASK[idx], independent of blanking.
- First frame after reset shows snap=0: digit 0 shows "0"; other digits blank if LZB=1, "0" if LZB=0.
- Reset mid-frame: all state to reset values; scan restarts at digit 0 on release.
- Counter widths: idx 3 bits; cnt $clog2(DWELL) bits, minimum 1.

Decomposition:
- Package stopwatch_pkg holds:
  - NUM_DIG=8;
  - SEG_0..SEG_9, SEG_E and SEG_BLANK active-low constants;
  - COM_OFF=8'hFF.
- Sub-module bcd_to_seg7: combinational 4-bit nibble -> 7-bit active-low pattern, with 'E' for values >9. The scanner instantiates it once on the selected nibble.

Test Plan:
- Reset: hold sw_reset=0 for 3 cycles, then pulse it low between clock edges. Required: fnd_com=8'hFF, fnd_seg=7'h7F, fnd_dp=1, frame_done=0, asserted without waiting for a clock edge.
- Frame timing (DWELL=2): release reset with val=0. Required: frame_done high one cycle, 16 cycles after release and every 16 thereafter. fnd_com steps FF,FE,FF,FD,...,FF,7F. First frame shows digit0=7'h40 and digits1-7=7'h7F.
- Decode + LZB: val=32'h0000_1234 before the first boundary. Required in frame 2: digit0=7'h19, digit1=7'h30, digit2=7'h24, digit3=7'h79, digits4-7=7'h7F. fnd_dp=0 on digits 2 and 4 only. With LZB=0, digits4-7 show 7'h40.
- Tear-free/hold: change val 32'h1234->32'h5678 mid-frame. Required: display unchanged until the next frame_done, then "5678". Then set hold=1 and val=32'h9999 across a boundary. Required: "5678" retained. Drop hold: "9999" after the next boundary.
- Error digit: val=32'h0000_00A0. Required: digit1=7'h06, digit0=7'h40, digits2-7 blank.
- DWELL=1 variant: no all-off cycles; frame_done period is 8 cycles.
